// File: rtl/alu_seq.sv
// Handshaked RV32I ALU: registered single-cycle ops plus an iterative restoring divider.
// Optional signed DIV/REM support is enabled with the ALU_SEQ_SIGNED_DIV_EN macro.
module alu_seq #(
    parameter  int WIDTH        = 32,
    parameter  int SHAMT_W      = $clog2(WIDTH),
    localparam int ALU_OP_WIDTH = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic [ALU_OP_WIDTH-1:0] operator_i,
    input  logic [WIDTH-1:0]        operand_a_i,
    input  logic [WIDTH-1:0]        operand_b_i,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [WIDTH-1:0]        result_o,
    output logic                    busy_o
);

    localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD  = 7'b0011000;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB  = 7'b0011001;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR  = 7'b0101111;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OR   = 7'b0101110;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_AND  = 7'b0010101;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SRA  = 7'b0100100;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL  = 7'b0100101;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL  = 7'b0100111;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTS = 7'b0000010;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTU = 7'b0000011;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_DIVU = 7'b0110000;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_REMU = 7'b0110010;
`ifdef ALU_SEQ_SIGNED_DIV_EN
    localparam logic [ALU_OP_WIDTH-1:0] ALU_DIV  = 7'b0110001;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_REM  = 7'b0110011;
`endif
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic {S_IDLE = 1'b0, S_DIV = 1'b1} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_dvd;
    logic [WIDTH-1:0]   r_dsr;
    logic [WIDTH-1:0]   r_rem;
    logic               r_op_rem;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_valid;
    logic [WIDTH-1:0]   r_result;

    logic               w_accept;
    logic               w_drain;
    logic               w_is_div;
    logic               w_is_signed;
    logic               w_op_rem;
    logic               w_ovf;
    logic               w_long;
    logic               w_step;
    logic               w_last;
    logic               w_ge;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH-1:0]   w_rem_nxt;
    logic [WIDTH-1:0]   w_quo_nxt;
    logic [WIDTH-1:0]   w_div_res;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;

    // Single-cycle result; divide ops only land here for the zero-divisor and overflow cases.
    function automatic logic [WIDTH-1:0] f_alu(
        input logic [ALU_OP_WIDTH-1:0] op,
        input logic [WIDTH-1:0]        a,
        input logic [WIDTH-1:0]        b
    );
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sb;
        logic [SHAMT_W-1:0]      sh;
        sa = a;
        sb = b;
        sh = b[SHAMT_W-1:0];
        f_alu = '0;
        case (op)
            ALU_ADD:  f_alu = a + b;
            ALU_SUB:  f_alu = a - b;
            ALU_AND:  f_alu = a & b;
            ALU_OR:   f_alu = a | b;
            ALU_XOR:  f_alu = a ^ b;
            ALU_SLL:  f_alu = a << sh;
            ALU_SRL:  f_alu = a >> sh;
            ALU_SRA:  f_alu = sa >>> sh;
            ALU_SLTS: f_alu = {{(WIDTH-1){1'b0}}, sa < sb};
            ALU_SLTU: f_alu = {{(WIDTH-1){1'b0}}, a < b};
            ALU_DIVU: f_alu = '1;
            ALU_REMU: f_alu = a;
`ifdef ALU_SEQ_SIGNED_DIV_EN
            ALU_DIV:  f_alu = (b == '0) ? '1 : MOST_NEG;
            ALU_REM:  f_alu = (b == '0) ? a : '0;
`endif
            default:  f_alu = '0;
        endcase
    endfunction

    always_comb begin
        w_is_signed = 1'b0;
        w_is_div    = (operator_i == ALU_DIVU) || (operator_i == ALU_REMU);
        w_op_rem    = (operator_i == ALU_REMU);
`ifdef ALU_SEQ_SIGNED_DIV_EN
        if ((operator_i == ALU_DIV) || (operator_i == ALU_REM)) begin
            w_is_div    = 1'b1;
            w_is_signed = 1'b1;
            w_op_rem    = (operator_i == ALU_REM);
        end
`endif
    end

    assign w_ovf    = w_is_signed & (operand_a_i == MOST_NEG) & (&operand_b_i);
    assign w_long   = w_is_div & (|operand_b_i) & ~w_ovf;
    assign w_mag_a  = (w_is_signed & operand_a_i[WIDTH-1]) ? -operand_a_i : operand_a_i;
    assign w_mag_b  = (w_is_signed & operand_b_i[WIDTH-1]) ? -operand_b_i : operand_b_i;

    assign w_accept = valid_i & ready_o;
    assign w_drain  = r_valid & ready_i;
    // The last iteration waits for an undrained result so it is never overwritten.
    assign w_step   = (r_state == S_DIV) & ~((r_cnt == '0) & r_valid & ~ready_i);
    assign w_last   = w_step & (r_cnt == '0);

    assign w_rem_sh  = {r_rem, r_dvd[WIDTH-1]};
    assign w_ge      = (w_rem_sh >= {1'b0, r_dsr});
    assign w_rem_nxt = w_ge ? WIDTH'(w_rem_sh - {1'b0, r_dsr}) : w_rem_sh[WIDTH-1:0];
    assign w_quo_nxt = {r_dvd[WIDTH-2:0], w_ge};
    assign w_div_res = r_op_rem ? (r_neg_r ? -w_rem_nxt : w_rem_nxt)
                                : (r_neg_q ? -w_quo_nxt : w_quo_nxt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && w_long) w_state_nxt = S_DIV;
            S_DIV:   if (w_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o  = (r_state == S_DIV);
        ready_o = (r_state == S_IDLE) & (~r_valid | ready_i);
    end

    // Divider operand / iteration stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_dvd    <= '0;
            r_dsr    <= '0;
            r_rem    <= '0;
            r_op_rem <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else if (w_accept && w_long) begin
            r_cnt    <= CNT_W'(WIDTH - 1);
            r_dvd    <= w_mag_a;
            r_dsr    <= w_mag_b;
            r_rem    <= '0;
            r_op_rem <= w_op_rem;
            r_neg_q  <= w_is_signed & (operand_a_i[WIDTH-1] ^ operand_b_i[WIDTH-1]);
            r_neg_r  <= w_is_signed & operand_a_i[WIDTH-1];
        end else if (w_step) begin
            r_rem <= w_rem_nxt;
            r_dvd <= w_quo_nxt;
            if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
    end

    // Single-entry output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_result <= '0;
        end else if (w_accept && !w_long) begin
            r_valid  <= 1'b1;
            r_result <= f_alu(operator_i, operand_a_i, operand_b_i);
        end else if (w_last) begin
            r_valid  <= 1'b1;
            r_result <= w_div_res;
        end else if (w_drain) begin
            r_valid  <= 1'b0;
        end
    end

    assign valid_o  = r_valid;
    assign result_o = r_result;

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the combinational RI5CY ALU.
- Executes the RV32I integer operations with a registered, 1-cycle result.
- Adds iterative unsigned divide and remainder (restoring, one quotient bit per cycle).
- Sits between the decode/issue stage and writeback; valid/ready on both sides, single-entry output register.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a power of two and at least 8.
- SHAMT_W, $clog2(WIDTH), number of low operand_b_i bits used as the shift amount.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- valid_i  input  1  request valid.
- ready_o  output  1  block can accept a request this cycle.
- operator_i  input  ALU_OP_WIDTH  operation, encoded with the riscv_defines ALU_* names.
- operand_a_i  input  WIDTH  operand A / dividend.
- operand_b_i  input  WIDTH  operand B / divisor / shift amount.
- valid_o  output  1  result valid.
- ready_i  input  1  consumer accepts the result.
- result_o  output  WIDTH  result, held stable while valid_o=1 and ready_i=0.
- busy_o  output  1  divider iterating (state DIV).

Behaviour:
- Reset (asynchronous, any cycle, including mid-divide):
  - state=IDLE; valid_o=0, result_o=0, busy_o=0.
  - Divider registers cleared; any in-flight operation is discarded.
- Handshake:
  - Accept when valid_i & ready_o at a rising edge.
  - ready_o = (state==IDLE) & (~valid_o | ready_i), so accept and drain may happen in the same cycle.
  - The result is consumed when valid_o & ready_i at an edge. valid_o falls unless a new result is written on the same edge.
- Single-cycle ops (latency 1; valid_o=1 after the accepting edge):
  - ADD, SUB: modulo 2^WIDTH.
  - AND, OR, XOR.
  - SLL, SRL, SRA: shift amount is operand_b_i[SHAMT_W-1:0]; SRA is arithmetic.
  - SLT (signed) and SLTU: result is zero-extended 0/1.
  - Back-to-back issue at 1 op/cycle when ready_i=1.
- Undefined operator_i: accepted; result_o=0 with valid_o=1 after 1 cycle.
- DIVU/REMU state machine (states IDLE, DIV):
  - IDLE -> DIV on accept of DIVU/REMU with divisor!=0.
    - Latch dividend, divisor and op; clear the remainder accumulator; counter=WIDTH-1.
  - DIV: each edge shifts one dividend bit into the remainder, compares against the divisor, and subtracts if the remainder is >= divisor. The quotient bit is shifted in; the counter decrements.
  - DIV -> IDLE on the edge where counter==0.
    - That same edge writes result_o (quotient for DIVU, remainder for REMU) and sets valid_o=1.
    - Latency is WIDTH cycles from the accepting edge.
  - busy_o=1 exactly while state==DIV; ready_o=0 throughout.
  - If valid_o is still pending from a prior op when entering DIV, ready_i is still honoured to drain it. The final DIV edge cannot occur before that drain: while valid_o=1 and ready_i=0 the counter holds at 0.
- Divide by zero (no iteration, latency 1):
  - DIVU result = all ones.
  - REMU result = operand_a_i.
- Operands are sampled only at accept; input changes during DIV have no effect.

Optional Feature:
- Macro: ALU_SEQ_SIGNED_DIV_EN.
- Defined: ALU_DIV and ALU_REM are also supported.
  - Operands are converted to magnitudes at accept and run through the same unsigned iteration.
  - The sign is fixed on the final DIV edge: quotient negated if the operand signs differ; remainder takes the dividend's sign. Latency is still WIDTH.
  - Divide by zero: DIV gives all ones, REM gives the dividend, latency 1.
  - Overflow (most-negative / -1): DIV gives the most-negative value, REM gives 0, latency 1.
- Undefined: ALU_DIV and ALU_REM are treated as undefined operators (result 0, latency 1).

Test Plan:
- WIDTH=32, ready_i=1, 1000 random pairs × ADD/SUB/AND/OR/XOR/SLL/SRL/SRA/SLT/SLTU issued back-to-back -> one result per cycle, each matching the golden model 1 cycle after accept. Example: SRA a=80000000 b=0000001F -> FFFFFFFF.
- DIVU a=00000064 b=00000007 -> busy_o high for 32 cycles, ready_o=0 throughout, result_o=0000000E. REMU with the same operands -> 00000002.
- DIVU a=12345678 b=00000000 -> FFFFFFFF after 1 cycle; REMU with the same operands -> 12345678 after 1 cycle.
- Backpressure: hold ready_i=0 for 5 cycles after an ADD (a=1, b=2) -> result_o=00000003 stable, ready_o=0; the next op is accepted on the same edge where ready_i=1 drains the result.
- Assert rst at cycle 10 of a DIVU -> outputs are 0 and state is IDLE immediately (asynchronously). The next ADD after deassertion completes normally with no stale result.
- With ALU_SEQ_SIGNED_DIV_EN defined:
  - DIV a=FFFFFF9C(-100) b=00000007 -> FFFFFFF2(-14); REM with the same operands -> FFFFFFFE(-2).
  - DIV a=80000000 b=FFFFFFFF -> 80000000 after 1 cycle.
